// File: rtl/ship_gun_if.sv
// Control and sprite-box bundle between the player/bullet controller and the draw stage.
// N_BULLETS must match the value given to the ship_gun instance on the other end.
interface ship_gun_if #(
  parameter int N_BULLETS = 4
);
  logic                   i_ani_stb;
  logic                   i_animate;
  logic [7:0]             i_sw;
  logic [11:0]            o_x1;
  logic [11:0]            o_x2;
  logic [11:0]            o_y1;
  logic [11:0]            o_y2;
  logic [12*N_BULLETS-1:0] o_bx1;
  logic [12*N_BULLETS-1:0] o_bx2;
  logic [12*N_BULLETS-1:0] o_by1;
  logic [12*N_BULLETS-1:0] o_by2;
  logic [N_BULLETS-1:0]   o_active;
  logic                   o_firing;
  logic                   o_shot;

  modport master (
    output i_ani_stb, i_animate, i_sw,
    input  o_x1, o_x2, o_y1, o_y2, o_bx1, o_bx2, o_by1, o_by2,
    input  o_active, o_firing, o_shot
  );

  modport slave (
    input  i_ani_stb, i_animate, i_sw,
    output o_x1, o_x2, o_y1, o_y2, o_bx1, o_bx2, o_by1, o_by2,
    output o_active, o_firing, o_shot
  );
endinterface

// File: rtl/ship_gun.sv
// Player ship with clamped movement and a pool of upward-flying bullets.
// State advances only on animation ticks; box edges are derived combinationally.
module ship_gun #(
  parameter int H_SIZE    = 16,
  parameter int B_SIZE    = 4,
  parameter int IX        = 320,
  parameter int IY        = 400,
  parameter int D_WIDTH   = 640,
  parameter int D_HEIGHT  = 480,
  parameter int N_BULLETS = 4,
  parameter int P_SPEED   = 2,
  parameter int B_SPEED   = 4,
  parameter int COOLDOWN  = 8,
  parameter int AUTO_FIRE = 0
) (
  input logic       i_clk,
  input logic       i_rst_n,
  ship_gun_if.slave bus
);
  localparam int XMIN = H_SIZE;
  localparam int XMAX = D_WIDTH - 1 - H_SIZE;
  localparam int YMIN = H_SIZE;
  localparam int YMAX = D_HEIGHT - 1 - H_SIZE;
  localparam int CW   = $clog2(COOLDOWN + 2);
  localparam int SW   = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;

  logic [11:0]          x, y, x_next, y_next;
  logic [11:0]          bx [N_BULLETS];
  logic [11:0]          by [N_BULLETS];
  logic [N_BULLETS-1:0] active;
  logic [CW-1:0]        cooldown;
  logic                 fire_prev;
  logic                 shot;
  logic                 tick, req, free_any, accept;
  logic                 right, left, up, down, fire;
  logic [SW-1:0]        slot;
  logic [11:0]          spawn_by;
  logic                 unused_sw;

  assign tick      = bus.i_animate & bus.i_ani_stb;
  assign right     = bus.i_sw[0];
  assign down      = bus.i_sw[1];
  assign fire      = bus.i_sw[4];
  assign up        = bus.i_sw[6];
  assign left      = bus.i_sw[7];
  assign unused_sw = ^{bus.i_sw[5], bus.i_sw[3:2]};

  // Opposing keys cancel; each axis saturates at its limit rather than overshooting.
  always_comb begin
    x_next = x;
    y_next = y;
    if (right && !left) begin
      if (int'(x) + P_SPEED > XMAX) x_next = 12'(XMAX);
      else                          x_next = x + 12'(P_SPEED);
    end else if (left && !right) begin
      if (int'(x) < XMIN + P_SPEED) x_next = 12'(XMIN);
      else                          x_next = x - 12'(P_SPEED);
    end
    if (down && !up) begin
      if (int'(y) + P_SPEED > YMAX) y_next = 12'(YMAX);
      else                          y_next = y + 12'(P_SPEED);
    end else if (up && !down) begin
      if (int'(y) < YMIN + P_SPEED) y_next = 12'(YMIN);
      else                          y_next = y - 12'(P_SPEED);
    end
  end

  always_comb begin
    free_any = 1'b0;
    slot     = '0;
    for (int k = N_BULLETS - 1; k >= 0; k--) begin
      if (!active[k]) begin
        free_any = 1'b1;
        slot     = SW'(k);
      end
    end
  end

  assign req      = (AUTO_FIRE != 0) ? fire : (fire & ~fire_prev);
  assign accept   = tick & req & (cooldown == '0) & free_any;
  assign spawn_by = y - 12'(H_SIZE + B_SIZE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x         <= 12'(IX);
      y         <= 12'(IY);
      cooldown  <= '0;
      fire_prev <= 1'b0;
      shot      <= 1'b0;
    end else begin
      shot <= accept;
      if (tick) begin
        x <= x_next;
        y <= y_next;
        if (AUTO_FIRE == 0) fire_prev <= fire;
        if (accept)                cooldown <= CW'(COOLDOWN);
        else if (cooldown != '0)   cooldown <= cooldown - CW'(1);
      end
    end
  end

  // A bullet never moves on its spawn tick; a retiring one parks at the pre-move player centre.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_BULLETS; k++) begin
        bx[k] <= 12'(IX);
        by[k] <= 12'(IY);
      end
      active <= '0;
    end else if (tick) begin
      for (int k = 0; k < N_BULLETS; k++) begin
        if (accept && slot == SW'(k)) begin
          active[k] <= 1'b1;
          bx[k]     <= x;
          by[k]     <= spawn_by;
        end else if (active[k]) begin
          if (int'(by[k]) < B_SIZE + B_SPEED) begin
            active[k] <= 1'b0;
            bx[k]     <= x;
            by[k]     <= y;
          end else begin
            by[k] <= by[k] - 12'(B_SPEED);
          end
        end
      end
    end
  end

  logic [12*N_BULLETS-1:0] bx1, bx2, by1, by2;

  always_comb begin
    bx1 = '0;
    bx2 = '0;
    by1 = '0;
    by2 = '0;
    for (int k = 0; k < N_BULLETS; k++) begin
      bx1[12*k +: 12] = bx[k] - 12'(B_SIZE);
      bx2[12*k +: 12] = bx[k] + 12'(B_SIZE);
      by1[12*k +: 12] = by[k] - 12'(B_SIZE);
      by2[12*k +: 12] = by[k] + 12'(B_SIZE);
    end
  end

  assign bus.o_x1     = x - 12'(H_SIZE);
  assign bus.o_x2     = x + 12'(H_SIZE);
  assign bus.o_y1     = y - 12'(H_SIZE);
  assign bus.o_y2     = y + 12'(H_SIZE);
  assign bus.o_bx1    = bx1;
  assign bus.o_bx2    = bx2;
  assign bus.o_by1    = by1;
  assign bus.o_by2    = by2;
  assign bus.o_active = active;
  assign bus.o_firing = |active;
  assign bus.o_shot   = shot;
endmodule

// File: tb/tb_ship_gun.sv
// Bench for ship_gun: three parameterisations share one clock and reset and are
// compared each tick against a behavioural model of the player and bullet pool.
module tb_ship_gun;
  typedef struct packed {
    int h; int b; int ix; int iy; int dw; int dh;
    int n; int ps; int bs; int cd; int af;
  } cfg_t;

  typedef struct packed {
    int               x;
    int               y;
    int               cd;
    logic             fprev;
    logic             shot;
    logic [15:0]      act;
    logic [15:0][11:0] bx;
    logic [15:0][11:0] by;
  } model_t;

  typedef struct packed {
    logic [11:0]       x1, x2, y1, y2;
    logic [15:0]       act;
    logic              firing, shot;
    logic [15:0][11:0] bx1, bx2, by1, by2;
  } obs_t;

  typedef struct packed {
    logic [7:0] sw;
    logic       anim;
    logic       stb;
    int         x1;
    int         y1;
  } vec_t;

  localparam logic [7:0] R = 8'h01;
  localparam logic [7:0] D = 8'h02;
  localparam logic [7:0] F = 8'h10;
  localparam logic [7:0] U = 8'h40;
  localparam logic [7:0] L = 8'h80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = '0;
  logic [2:0] anim = '0;
  logic       stb = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  cfg_t   cfg [3];
  model_t mdl [3];

  ship_gun_if #(.N_BULLETS(4)) bus0 ();
  ship_gun_if #(.N_BULLETS(4)) bus1 ();
  ship_gun_if #(.N_BULLETS(1)) bus2 ();

  assign bus0.i_sw = sw;  assign bus0.i_ani_stb = stb;  assign bus0.i_animate = anim[0];
  assign bus1.i_sw = sw;  assign bus1.i_ani_stb = stb;  assign bus1.i_animate = anim[1];
  assign bus2.i_sw = sw;  assign bus2.i_ani_stb = stb;  assign bus2.i_animate = anim[2];

  ship_gun #(.AUTO_FIRE(0)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
  ship_gun #(.AUTO_FIRE(1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));
  ship_gun #(.N_BULLETS(1), .COOLDOWN(0), .P_SPEED(1), .AUTO_FIRE(1))
    dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus2));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic model_t model_reset(cfg_t c);
    model_t m;
    m = '0;
    m.x = c.ix;
    m.y = c.iy;
    for (int i = 0; i < 16; i++) begin
      m.bx[i] = 12'(c.ix);
      m.by[i] = 12'(c.iy);
    end
    return m;
  endfunction

  // Spec-level rules applied to one tick: move, fire request, flight, allocation, cooldown.
  function automatic model_t model_step(model_t m, cfg_t c, logic tk, logic [7:0] s);
    model_t nx;
    int     xmax, ymax, slot;
    logic   rq;
    nx = m;
    nx.shot = 1'b0;
    if (!tk) return nx;
    xmax = c.dw - 1 - c.h;
    ymax = c.dh - 1 - c.h;
    if (s[0] && !s[7])      nx.x = (m.x + c.ps > xmax) ? xmax : m.x + c.ps;
    else if (s[7] && !s[0]) nx.x = (m.x < c.h + c.ps) ? c.h : m.x - c.ps;
    if (s[1] && !s[6])      nx.y = (m.y + c.ps > ymax) ? ymax : m.y + c.ps;
    else if (s[6] && !s[1]) nx.y = (m.y < c.h + c.ps) ? c.h : m.y - c.ps;
    rq = (c.af != 0) ? s[4] : (s[4] && !m.fprev);
    if (c.af == 0) nx.fprev = s[4];
    slot = -1;
    for (int i = c.n - 1; i >= 0; i--) if (!m.act[i]) slot = i;
    for (int i = 0; i < c.n; i++) begin
      if (m.act[i]) begin
        if (int'(m.by[i]) < c.b + c.bs) begin
          nx.act[i] = 1'b0;
          nx.bx[i]  = 12'(m.x);
          nx.by[i]  = 12'(m.y);
        end else begin
          nx.by[i] = 12'(int'(m.by[i]) - c.bs);
        end
      end
    end
    if (rq && m.cd == 0 && slot >= 0) begin
      nx.act[slot] = 1'b1;
      nx.bx[slot]  = 12'(m.x);
      nx.by[slot]  = 12'((m.y - c.h - c.b) & 4095);
      nx.cd        = c.cd;
      nx.shot      = 1'b1;
    end else if (m.cd > 0) begin
      nx.cd = m.cd - 1;
    end
    return nx;
  endfunction

  task automatic cmp(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic read_dut(input int k, output obs_t o);
    o = '0;
    case (k)
      0: begin
        o.x1 = bus0.o_x1; o.x2 = bus0.o_x2; o.y1 = bus0.o_y1; o.y2 = bus0.o_y2;
        o.act = 16'(bus0.o_active); o.firing = bus0.o_firing; o.shot = bus0.o_shot;
        o.bx1[3:0] = bus0.o_bx1; o.bx2[3:0] = bus0.o_bx2;
        o.by1[3:0] = bus0.o_by1; o.by2[3:0] = bus0.o_by2;
      end
      1: begin
        o.x1 = bus1.o_x1; o.x2 = bus1.o_x2; o.y1 = bus1.o_y1; o.y2 = bus1.o_y2;
        o.act = 16'(bus1.o_active); o.firing = bus1.o_firing; o.shot = bus1.o_shot;
        o.bx1[3:0] = bus1.o_bx1; o.bx2[3:0] = bus1.o_bx2;
        o.by1[3:0] = bus1.o_by1; o.by2[3:0] = bus1.o_by2;
      end
      default: begin
        o.x1 = bus2.o_x1; o.x2 = bus2.o_x2; o.y1 = bus2.o_y1; o.y2 = bus2.o_y2;
        o.act = 16'(bus2.o_active); o.firing = bus2.o_firing; o.shot = bus2.o_shot;
        o.bx1[0] = bus2.o_bx1; o.bx2[0] = bus2.o_bx2;
        o.by1[0] = bus2.o_by1; o.by2[0] = bus2.o_by2;
      end
    endcase
  endtask

  task automatic check_output(input int k, input string tag);
    obs_t   o;
    model_t m;
    cfg_t   c;
    string  p;
    read_dut(k, o);
    m = mdl[k];
    c = cfg[k];
    p = $sformatf("%s dut%0d", tag, k);
    cmp({p, " x1"}, int'(o.x1), m.x - c.h);
    cmp({p, " x2"}, int'(o.x2), m.x + c.h);
    cmp({p, " y1"}, int'(o.y1), m.y - c.h);
    cmp({p, " y2"}, int'(o.y2), m.y + c.h);
    cmp({p, " active"}, int'(o.act), int'(m.act));
    cmp({p, " firing"}, int'(o.firing), int'(m.act != 0));
    cmp({p, " shot"}, int'(o.shot), int'(m.shot));
    for (int i = 0; i < c.n; i++) begin
      cmp($sformatf("%s bx1[%0d]", p, i), int'(o.bx1[i]), (int'(m.bx[i]) - c.b) & 4095);
      cmp($sformatf("%s bx2[%0d]", p, i), int'(o.bx2[i]), (int'(m.bx[i]) + c.b) & 4095);
      cmp($sformatf("%s by1[%0d]", p, i), int'(o.by1[i]), (int'(m.by[i]) - c.b) & 4095);
      cmp($sformatf("%s by2[%0d]", p, i), int'(o.by2[i]), (int'(m.by[i]) + c.b) & 4095);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] s, input logic [2:0] en, input logic st);
    @(negedge clk);
    sw   = s;
    anim = en;
    stb  = st;
    @(posedge clk);
    for (int k = 0; k < 3; k++) mdl[k] = model_step(mdl[k], cfg[k], en[k] & st, s);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sw    = '0;
    anim  = '0;
    stb   = 1'b0;
    for (int k = 0; k < 3; k++) mdl[k] = model_reset(cfg[k]);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t tbl [9];
    obs_t o;
    int   exp_x;

    cfg[0] = '{h:16, b:4, ix:320, iy:400, dw:640, dh:480, n:4, ps:2, bs:4, cd:8, af:0};
    cfg[1] = '{h:16, b:4, ix:320, iy:400, dw:640, dh:480, n:4, ps:2, bs:4, cd:8, af:1};
    cfg[2] = '{h:16, b:4, ix:320, iy:400, dw:640, dh:480, n:1, ps:1, bs:4, cd:0, af:1};

    tbl[0] = '{sw:R,     anim:1'b1, stb:1'b1, x1:306, y1:384};
    tbl[1] = '{sw:R | L, anim:1'b1, stb:1'b1, x1:306, y1:384};
    tbl[2] = '{sw:U,     anim:1'b0, stb:1'b1, x1:306, y1:384};
    tbl[3] = '{sw:U,     anim:1'b1, stb:1'b0, x1:306, y1:384};
    tbl[4] = '{sw:U,     anim:1'b1, stb:1'b1, x1:306, y1:382};
    tbl[5] = '{sw:U | D, anim:1'b1, stb:1'b1, x1:306, y1:382};
    tbl[6] = '{sw:D,     anim:1'b1, stb:1'b1, x1:306, y1:384};
    tbl[7] = '{sw:L,     anim:1'b1, stb:1'b1, x1:304, y1:384};
    tbl[8] = '{sw:L | D, anim:1'b1, stb:1'b1, x1:302, y1:386};

    // Reset and idle
    do_reset();
    read_dut(0, o);
    cmp("reset x1", int'(o.x1), 304);
    cmp("reset x2", int'(o.x2), 336);
    cmp("reset y1", int'(o.y1), 384);
    cmp("reset y2", int'(o.y2), 416);
    cmp("reset active", int'(o.act), 0);
    cmp("reset firing", int'(o.firing), 0);
    for (int k = 0; k < 3; k++) check_output(k, "reset");

    // Table of movement vectors
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(tbl[i].sw, {2'b00, tbl[i].anim}, tbl[i].stb);
      read_dut(0, o);
      cmp($sformatf("table[%0d] x1", i), int'(o.x1), tbl[i].x1);
      cmp($sformatf("table[%0d] y1", i), int'(o.y1), tbl[i].y1);
      check_output(0, "table");
    end

    // Left clamp
    do_reset();
    for (int t = 0; t < 160; t++) begin
      apply_stimulus(L, 3'b001, 1'b1);
      exp_x = 320 - 2 * (t + 1);
      if (exp_x < 16) exp_x = 16;
      read_dut(0, o);
      cmp($sformatf("clamp t%0d x1", t), int'(o.x1), exp_x - 16);
      check_output(0, "clamp");
    end
    apply_stimulus(R | L, 3'b001, 1'b1);
    read_dut(0, o);
    cmp("clamp right+left x1", int'(o.x1), 0);
    apply_stimulus(R, 3'b000, 1'b1);
    read_dut(0, o);
    cmp("clamp no-animate x1", int'(o.x1), 0);

    // Single edge-triggered shot, then held fire
    do_reset();
    apply_stimulus(F, 3'b001, 1'b1);
    read_dut(0, o);
    cmp("single shot", int'(o.shot), 1);
    cmp("single bx1", int'(o.bx1[0]), 316);
    cmp("single by1", int'(o.by1[0]), 376);
    check_output(0, "single");
    apply_stimulus(F, 3'b001, 1'b0);
    read_dut(0, o);
    cmp("single shot drop", int'(o.shot), 0);
    cmp("single by1 idle", int'(o.by1[0]), 376);
    for (int t = 1; t <= 100; t++) begin
      apply_stimulus(F, 3'b001, 1'b1);
      read_dut(0, o);
      cmp($sformatf("held t%0d shot", t), int'(o.shot), 0);
      if (t == 1)  cmp("flight t1 by1", int'(o.by1[0]), 372);
      if (t == 94) begin
        cmp("flight t94 by1", int'(o.by1[0]), 0);
        cmp("flight t94 active", int'(o.act), 1);
      end
      if (t == 95) begin
        cmp("retire t95 active", int'(o.act), 0);
        cmp("retire t95 bx1", int'(o.bx1[0]), 316);
        cmp("retire t95 by1", int'(o.by1[0]), 396);
      end
      check_output(0, "single");
    end

    // Auto-fire with cooldown and pool exhaustion
    do_reset();
    for (int t = 0; t < 100; t++) begin
      apply_stimulus(F, 3'b010, 1'b1);
      read_dut(1, o);
      cmp($sformatf("auto t%0d shot", t), int'(o.shot),
          int'(t == 0 || t == 9 || t == 18 || t == 27 || t == 96));
      if (t == 36) cmp("auto t36 active", int'(o.act), 15);
      if (t == 95) cmp("auto t95 active", int'(o.act), 14);
      if (t == 96) begin
        cmp("auto t96 active", int'(o.act), 15);
        cmp("auto t96 by1[0]", int'(o.by1[0]), 376);
      end
      check_output(1, "auto");
    end

    // Asynchronous reset mid-flight
    do_reset();
    repeat (5) apply_stimulus(R, 3'b001, 1'b1);
    for (int s = 0; s < 3; s++) begin
      apply_stimulus(F, 3'b001, 1'b1);
      repeat (8) apply_stimulus(8'h00, 3'b001, 1'b1);
    end
    read_dut(0, o);
    cmp("pre-reset active", int'(o.act), 7);
    cmp("pre-reset x1", int'(o.x1), 314);
    #1;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) mdl[k] = model_reset(cfg[k]);
    #1;
    read_dut(0, o);
    cmp("async active", int'(o.act), 0);
    cmp("async x1", int'(o.x1), 304);
    cmp("async firing", int'(o.firing), 0);
    check_output(0, "async");
    @(negedge clk);
    rst_n = 1'b1;

    // Single-slot pool, no cooldown, slow player
    do_reset();
    for (int t = 0; t < 400; t++) begin
      apply_stimulus(R | F, 3'b100, 1'b1);
      exp_x = 320 + t + 1;
      if (exp_x > 623) exp_x = 623;
      read_dut(2, o);
      cmp($sformatf("sweep t%0d shot", t), int'(o.shot), int'(t % 96 == 0));
      cmp($sformatf("sweep t%0d x1", t), int'(o.x1), exp_x - 16);
      check_output(2, "sweep");
    end

    // Randomised traffic on all three instances
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      apply_stimulus(8'($urandom), 3'($urandom), $urandom_range(0, 9) < 8);
      for (int k = 0; k < 3; k++) check_output(k, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ship_gun.md
Name: ship_gun

Overview:
Next-generation player ship controller for the shooter display pipeline.
- Tracks the player square and a parametrised pool of N_BULLETS independent bullets.
- Adds per-tick movement speed, saturating boundary clamps, fire cooldown, edge-triggered or auto-fire modes, and lowest-free-slot bullet allocation.
- Feeds box coordinates to the sprite/draw stage and collision logic.

Parameters:
H_SIZE, 16, player half-width in pixels
B_SIZE, 4, bullet half-width in pixels
IX, 320, initial player centre x
IY, 400, initial player centre y
D_WIDTH, 640, display width
D_HEIGHT, 480, display height
N_BULLETS, 4, bullet pool depth (1..16)
P_SPEED, 2, player pixels per tick
B_SPEED, 4, bullet pixels per tick (upward)
COOLDOWN, 8, ticks before another shot may be accepted
AUTO_FIRE, 0, 0 = fire on rising edge of fire switch; 1 = fire whenever held

Ports:
i_clk  in  1  base clock
i_rst_n  in  1  reset, asynchronous, active-low
i_ani_stb  in  1  animation strobe
i_animate  in  1  animation enable
i_sw  in  8  controls: [0] right, [7] left, [6] up, [1] down, [4] fire
o_x1, o_x2, o_y1, o_y2  out  12 each  player left/right/top/bottom edges
o_bx1, o_bx2, o_by1, o_by2  out  12*N_BULLETS each  bullet k edges, packed; bullet k occupies bits [12k+11:12k]
o_active  out  N_BULLETS  bullet k in flight
o_firing  out  1  OR of o_active
o_shot  out  1  one-clock pulse on an accepted shot

Behaviour:
Clock and reset (already decided):
- One clock, i_clk; reset is asynchronous and active-low, i_rst_n.
- Reset (immediate, independent of clock) sets:
  - x=IX, y=IY.
  - Every bullet bx=IX, by=IY, active=0.
  - cooldown=0, fire_prev=0, o_shot=0.
- Reset asserted mid-flight kills all bullets at once.

Tick and timing:
- tick = i_animate & i_ani_stb. All state changes only on clock edges where tick=1.
- o_shot is registered and high only for the clock of an accepted tick.
- Edge outputs are combinational from state: box = centre ± size, 12-bit wrap-free because of the clamps below.

Player movement:
- Right and left together: no x change. Up and down together: no y change.
- Right: x = x+P_SPEED, saturated at XMAX = D_WIDTH-1-H_SIZE.
- Left: if x < H_SIZE+P_SPEED then x=H_SIZE, else x-P_SPEED.
- y is handled the same way, with YMIN=H_SIZE and YMAX=D_HEIGHT-1-H_SIZE.
- A move landing exactly on a limit is allowed. No overshoot ever.

Fire request (per tick):
- AUTO_FIRE=0: req = sw[4] & ~fire_prev. fire_prev <= sw[4], updated on ticks only.
- AUTO_FIRE=1: req = sw[4].

Shot acceptance:
- A shot is accepted when req & cooldown==0 & a free slot exists.
- Allocation goes to the lowest-index inactive slot.
- The new bullet spawns with bx=x and by=y-H_SIZE-B_SIZE, using pre-move x,y from the same tick. It sets active=1 and does not move on its spawn tick.
- cooldown <= COOLDOWN on acceptance. Otherwise it decrements on each tick if nonzero.
- Minimum spacing between accepted shots is therefore COOLDOWN+1 ticks.
- Pool full: request dropped, no o_shot, cooldown unchanged. In edge mode the edge is consumed.

Bullet motion (each active bullet, not the one spawning this tick):
- If by < B_SIZE+B_SPEED: active <= 0 and bx,by <= current x,y.
- Otherwise by <= by-B_SPEED.
- A slot freed on tick T can be reallocated on tick T+1, not on T.
- Inactive bullets output the coordinates of their last retire/reset position. Consumers must gate them with o_active.

Test Plan:
- Reset and idle:
  - Stimulus: hold i_rst_n=0, then release with no switches.
  - Required: o_x1=304, o_x2=336, o_y1=384, o_y2=416, o_active=0, o_firing=0.
- Clamp and simultaneous keys:
  - Stimulus: hold left for 160 ticks.
  - Required: x=16 from tick 152 on, o_x1=0.
  - Stimulus: right+left together.
  - Required: x unchanged. Ticks with i_animate=0 cause no movement.
- Single shot and flight:
  - Stimulus: AUTO_FIRE=0, pulse sw[4] for one tick at x=320,y=400.
  - Required: o_shot for one clock; slot 0 bx=320, by=380; by=376 the next tick; by=4 after 94 ticks; o_active[0]=0 on tick 95.
  - Stimulus: holding sw[4] afterwards.
  - Required: no further shots.
- Auto-fire, cooldown and pool exhaustion:
  - Stimulus: AUTO_FIRE=1, hold sw[4].
  - Required: shots at ticks 0, 9, 18, 27 into slots 0..3. Tick 36 is dropped with no o_shot. Next shot lands the tick after slot 0 retires (tick 96), into slot 0.
- Async reset mid-flight:
  - Stimulus: drop i_rst_n between clock edges with 3 bullets active.
  - Required: o_active=0 and x=320 immediately, before the next clock edge.
- Parameter sweep:
  - Stimulus: N_BULLETS=1, COOLDOWN=0, P_SPEED=1.
  - Required: second shot rejected until the first retires; player reaches XMAX=623 and holds there.
